// File: rtl/reg_file_autoinit.sv
// reg_file_autoinit: multi-read-port register file that fills itself with
// mem[i] = i after reset or on request before accepting writes.
// Address 0 is hard-wired to read 0 and ignores writes.
// Optional macro REGFILE_BYPASS_EN: when defined, a read that hits the address
// being written in the same cycle returns the new data (write-first);
// otherwise the old contents are returned until the write edge (read-first).
module reg_file_autoinit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       init_req,
    output logic                       ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    // A user write that would actually land in RUN: non-zero address and
    // not cancelled by a simultaneous re-initialisation request.
    logic                user_wr_s;
    assign user_wr_s = wr_en && (wr_addr != {ADDR_W{1'b0}}) && !init_req;

    logic [DATA_W-1:0]   rd_port_s [NUM_RD];

    // Next-state, init counter, ready and memory write-port selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = DATA_W'(cnt_q);
        case (state_q)
            ST_INIT: begin
                if (init_req) begin
                    // Restart the sweep; this edge writes nothing.
                    cnt_d   = {ADDR_W{1'b0}};
                    ready_d = 1'b0;
                end else begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cnt_q;
                    mem_wdata_s = DATA_W'(cnt_q);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        // Last entry written: single pass, no wrap.
                        state_d = ST_RUN;
                        cnt_d   = {ADDR_W{1'b0}};
                        ready_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    // Same-cycle write is dropped in favour of re-init.
                    state_d = ST_INIT;
                    cnt_d   = {ADDR_W{1'b0}};
                    ready_d = 1'b0;
                end else if (user_wr_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_addr;
                    mem_wdata_s = wr_data;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_W{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // Control state: asynchronous reset forces INIT with the sweep at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_W{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Storage array; contents are defined only once the init sweep rewrites them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] ra_s;
            assign ra_s = rd_addr[k*ADDR_W +: ADDR_W];

            // Combinational read: zero while initialising or for address 0.
            always_comb begin
                rd_port_s[k] = {DATA_W{1'b0}};
                if ((state_q == ST_RUN) && (ra_s != {ADDR_W{1'b0}})) begin
`ifdef REGFILE_BYPASS_EN
                    if (user_wr_s && (ra_s == wr_addr)) begin
                        rd_port_s[k] = wr_data;
                    end else begin
                        rd_port_s[k] = mem_q[ra_s];
                    end
`else
                    rd_port_s[k] = mem_q[ra_s];
`endif
                end else begin
                    rd_port_s[k] = {DATA_W{1'b0}};
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = rd_port_s[k];
        end
    endgenerate

    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_autoinit.sv
// Self-checking bench for reg_file_autoinit: default-parameter instance driven
// by directed and random stimulus against a behavioural model, plus a small
// ADDR_W=3 / DATA_W=8 / NUM_RD=4 instance.
module tb_reg_file_autoinit;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_req;
    logic        ready;

    logic        rst_s;
    logic [11:0] rd_addr_s;
    logic [31:0] rd_data_s;
    logic        wr_en_s;
    logic [2:0]  wr_addr_s;
    logic [7:0]  wr_data_s;
    logic        init_req_s;
    logic        ready_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the default instance.
    logic [31:0] m_mem [32];
    bit          m_run;
    int          m_cnt;

    reg_file_autoinit dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_req(init_req), .ready(ready)
    );

    reg_file_autoinit #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4)) dut_small (
        .clk(clk), .rst(rst_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .init_req(init_req_s), .ready(ready_s)
    );

    // Rising edges at 10, 20, 30 ... ns
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5 clk = 1'b0;
            #5;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_run || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !init_req && wr_addr == a) return wr_data;
`endif
        return m_mem[a];
    endfunction

    // Apply the effect of the coming rising edge to the model, then advance.
    task automatic tick();
        if (rst) begin
            m_run = 0;
            m_cnt = 0;
        end else if (init_req) begin
            m_run = 0;
            m_cnt = 0;
        end else if (!m_run) begin
            m_mem[m_cnt] = 32'(m_cnt);
            m_cnt++;
            if (m_cnt == 32) m_run = 1;
        end else if (wr_en && wr_addr != 5'd0) begin
            m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    // Runs a full init sweep, checking ready rises exactly at edge 32.
    task automatic run_init_sweep(input string tag);
        for (int e = 1; e <= 32; e++) begin
            tick();
            n_checks++;
            if (ready !== (e == 32)) begin
                n_fail++;
                $display("FAIL %s ready edge %0d: got %b expected %b", tag, e, ready, (e == 32));
            end
            if (e < 32) begin
                n_checks++;
                if (rd_data !== 64'd0) begin
                    n_fail++;
                    $display("FAIL %s rd_data during init edge %0d: got %h expected 0", tag, e, rd_data);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready: got %b expected 0", ready);
        end
        n_checks++;
        if (rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset rd_data: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_init_latency();
        rd_addr = {5'd31, 5'd5};
        #80;            // rst released at 85 ns, mid-cycle
        rst = 1'b0;
        m_run = 0;
        m_cnt = 0;
        run_init_sweep("init");
        n_checks++;
        if (rd_data[31:0] !== 32'd5) begin
            n_fail++;
            $display("FAIL init rd5: got %h expected %h", rd_data[31:0], 32'd5);
        end
        n_checks++;
        if (rd_data[63:32] !== 32'd31) begin
            n_fail++;
            $display("FAIL init rd31: got %h expected %h", rd_data[63:32], 32'd31);
        end
    endtask

    task automatic test_write_basic();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd1;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'd1) begin
            n_fail++;
            $display("FAIL write3: got %h expected %h", rd_data[31:0], 32'd1);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        rd_addr = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL addr0 same cycle: got %h expected 0", rd_data);
        end
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL addr0 after write: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h1234;
`else
        exp_same = 32'd6;
`endif
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1234;
        rd_addr = {5'd6, 5'd6};
        #1;
        n_checks++;
        if (rd_data[31:0] !== exp_same) begin
            n_fail++;
            $display("FAIL bypass port0: got %h expected %h", rd_data[31:0], exp_same);
        end
        n_checks++;
        if (rd_data[63:32] !== exp_same) begin
            n_fail++;
            $display("FAIL bypass port1: got %h expected %h", rd_data[63:32], exp_same);
        end
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'h1234) begin
            n_fail++;
            $display("FAIL after write6: got %h expected %h", rd_data[31:0], 32'h1234);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a0, a1;
        logic [31:0] e0, e1;
        for (int i = 0; i < 300; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            a0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr = {a1, a0};
            #1;
            e0 = exp_rd(a0);
            e1 = exp_rd(a1);
            n_checks++;
            if (rd_data[31:0] !== e0) begin
                n_fail++;
                $display("FAIL random port0 iter %0d addr %0d: got %h expected %h", i, a0, rd_data[31:0], e0);
            end
            n_checks++;
            if (rd_data[63:32] !== e1) begin
                n_fail++;
                $display("FAIL random port1 iter %0d addr %0d: got %h expected %h", i, a1, rd_data[63:32], e1);
            end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random ready iter %0d: got %b expected 1", i, ready);
            end
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_init_req();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        tick();
        rd_addr = {5'd0, 5'd9};
        // Pulse init_req together with a write that must be dropped
        wr_data = 32'h55;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        // Writes during INIT are ignored
        wr_data = 32'h77;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_req ready: got %b expected 0", ready);
        end
        run_init_sweep("init_req");
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'd9) begin
            n_fail++;
            $display("FAIL init_req mem9: got %h expected %h", rd_data[31:0], 32'd9);
        end
        // Re-request in the middle of INIT restarts the count
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int e = 0; e < 20; e++) tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        run_init_sweep("init_restart");
    endtask

    task automatic test_async_reset();
        rd_addr = {5'd31, 5'd9};
        #2;
        rst = 1'b1;
        m_run = 0;
        m_cnt = 0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL async reset in run: got ready %b rd %h expected 0/0", ready, rd_data);
        end
        tick();
        tick();
        #2;
        rst = 1'b0;
        run_init_sweep("rst_run");
        // Reset in the middle of INIT at cnt == 10
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        #2;
        rst = 1'b1;
        m_run = 0;
        m_cnt = 0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL async reset in init: got ready %b rd %h expected 0/0", ready, rd_data);
        end
        tick();
        #2;
        rst = 1'b0;
        run_init_sweep("rst_init");
        #1;
        n_checks++;
        if (rd_data !== {32'd31, 32'd9}) begin
            n_fail++;
            $display("FAIL after reset reads: got %h expected %h", rd_data, {32'd31, 32'd9});
        end
    endtask

    task automatic test_small();
        logic [31:0] exp_s;
        rd_addr_s = {3'd7, 3'd7, 3'd2, 3'd1};
        #2;
        rst_s = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ready_s !== (e == 8)) begin
                n_fail++;
                $display("FAIL small ready edge %0d: got %b expected %b", e, ready_s, (e == 8));
            end
        end
        exp_s = {8'd7, 8'd7, 8'd2, 8'd1};
        n_checks++;
        if (rd_data_s !== exp_s) begin
            n_fail++;
            $display("FAIL small reads: got %h expected %h", rd_data_s, exp_s);
        end
        wr_en_s = 1'b1; wr_addr_s = 3'd2; wr_data_s = 8'hA5;
        @(posedge clk);
        #1;
        wr_en_s = 1'b0;
        #1;
        exp_s = {8'd7, 8'd7, 8'hA5, 8'd1};
        n_checks++;
        if (rd_data_s !== exp_s) begin
            n_fail++;
            $display("FAIL small write: got %h expected %h", rd_data_s, exp_s);
        end
    endtask

    initial begin
        rst = 1'b0; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0;
        wr_data = 32'd0; init_req = 1'b0;
        rst_s = 1'b0; rd_addr_s = 12'd0; wr_en_s = 1'b0; wr_addr_s = 3'd0;
        wr_data_s = 8'd0; init_req_s = 1'b0;
        m_run = 0;
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        #2;
        rst = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_init_latency();
        test_write_basic();
        test_bypass();
        test_random();
        test_init_req();
        test_async_reset();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_autoinit.md
REG_FILE_AUTOINIT -- requirements
Module: reg_file_autoinit

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits; SHALL be >= ADDR_W.
REQ-002 Parameter ADDR_W, default 5: register address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port rd_addr  input  NUM_RD*ADDR_W: read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 Port rd_data  output  NUM_RD*DATA_W: read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-008 Port wr_en  input  1: write strobe.
REQ-009 Port wr_addr  input  ADDR_W: write address.
REQ-010 Port wr_data  input  DATA_W: write data.
REQ-011 Port init_req  input  1: request re-initialisation of all registers.
REQ-012 Port ready  output  1: high when the file is initialised and accepting writes.

Function
REQ-013 FSM states: INIT, RUN; INIT holds counter cnt (ADDR_W bits).
REQ-014 In INIT, each rising edge SHALL write mem[cnt] = cnt zero-extended to DATA_W, then increment cnt.
REQ-015 At the edge writing cnt == DEPTH-1, state SHALL go to RUN and ready SHALL go high; no wrap to a second pass.
REQ-016 Initialisation latency: ready high exactly DEPTH rising edges after rst deasserts (32 at defaults).
REQ-017 In INIT, wr_en SHALL be ignored and every rd_data port SHALL read 0.
REQ-018 In RUN, a rising edge with wr_en=1 and wr_addr != 0 SHALL write wr_data to mem[wr_addr].
REQ-019 Writes to address 0 SHALL be discarded; reads of address 0 SHALL always return 0.
REQ-020 In RUN, rd_data port k SHALL be combinational mem[rd_addr k]; all ports independent, same address on several ports allowed.
REQ-021 init_req=1 in RUN: next edge SHALL enter INIT, cnt=0, ready=0; the same-cycle write SHALL be dropped.
REQ-022 init_req=1 in INIT: next edge SHALL restart cnt at 0 (latency counted from the last init_req edge).
REQ-023 Reset asserted mid-INIT or mid-RUN SHALL abort and restart initialisation from cnt=0 after release.

Reset
REQ-024 While rst=1: state=INIT, cnt=0, ready=0, rd_data all 0; memory contents undefined until rewritten by INIT.
REQ-025 Reset SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: in RUN, a read port whose address equals wr_addr while wr_en=1 and wr_addr != 0 SHALL return wr_data in the same cycle (write-first).
REQ-027 Macro REGFILE_BYPASS_EN undefined: such a read SHALL return the old contents until after the write edge (read-first).
REQ-028 The macro SHALL not change init latency, address-0 behaviour or port list.

Verification
REQ-029 Defaults, rst high 85 ns then low -> ready low for 31 edges, high after edge 32; rd_addr0=5, rd_addr1=31 then read 5 and 31.
REQ-030 After ready: wr_en=1, wr_addr=3, wr_data=1 -> next cycle rd_addr0=3 reads 1; wr_addr=0, wr_data=0xFFFF_FFFF -> address 0 still reads 0.
REQ-031 Same cycle wr_addr=6, wr_data=0x1234, rd_addr0=6 -> 0x1234 with REGFILE_BYPASS_EN, 6 without; 0x1234 both after edge.
REQ-032 After writing mem[9]=0xAA, pulse init_req one cycle -> ready low for 32 edges, rd_data 0 meanwhile, then mem[9] reads 9.
REQ-033 Assert rst asynchronously mid-INIT at cnt=10 -> ready and rd_data 0 immediately; after release ready rises after 32 edges.
REQ-034 ADDR_W=3, DATA_W=8, NUM_RD=4 -> ready after 8 edges; four ports on addresses 1,2,7,7 read 1,2,7,7.
